// File: rtl/adc_pipe_decimator_fifo_if.sv
// Valid/ready read-out bus carrying decimated sums from the decimator FIFO to a consumer.
interface adc_pipe_decimator_fifo_if #(
  parameter int DATA_BITS = 5
) ();
  logic                 valid_o;
  logic [DATA_BITS-1:0] data_o;
  logic                 ready_i;

  modport master (output valid_o, output data_o, input ready_i);
  modport slave  (input valid_o, input data_o, output ready_i);
endinterface

// File: rtl/adc_pipe_decimator_fifo.sv
// Drops encoder pipeline-fill samples, boxcar-sums blocks of 2^AVG_LOG2 codes and
// queues the sums in a first-word-fall-through FIFO read over a valid/ready bus.
module adc_pipe_decimator_fifo #(
  parameter int NUM_BITS        = 3,
  parameter int AVG_LOG2        = 2,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int FILL_CYCLES     = 3
) (
  input  logic                       clock_i,
  input  logic                       reset_ni,
  input  logic                       enable_i,
  input  logic [NUM_BITS-1:0]        d_i,
  input  logic                       clr_ovf_i,
  output logic [FIFO_DEPTH_LOG2:0]   level_o,
  output logic                       overflow_o,
  adc_pipe_decimator_fifo_if.master  bus_if
);
  localparam int OUT_BITS = NUM_BITS + AVG_LOG2;
  localparam int DEPTH    = 1 << FIFO_DEPTH_LOG2;
  localparam int SMP_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FILL_W   = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
  localparam int PTR_W    = (FIFO_DEPTH_LOG2 > 0) ? FIFO_DEPTH_LOG2 : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_ACCUM = 2'd2;

  localparam logic [SMP_W-1:0]         SMP_MAX    = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [FILL_W-1:0]        FILL_LAST  = FILL_W'((FILL_CYCLES > 0) ? FILL_CYCLES - 1 : 0);
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [PTR_W-1:0]         PTR_LAST   = PTR_W'(DEPTH - 1);

  logic [1:0]          state;
  logic [FILL_W-1:0]   fill_cnt;
  logic [SMP_W-1:0]    smp_cnt;
  logic [OUT_BITS-1:0] acc;
  logic [OUT_BITS-1:0] acc_next;
  logic                push_req;

  logic [OUT_BITS-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [FIFO_DEPTH_LOG2:0] level_q;
  logic                     empty;
  logic                     full;
  logic                     pop;
  logic                     push_ok;
  logic                     drop;

  assign acc_next = acc + OUT_BITS'(d_i);
  assign push_req = enable_i && (state == ST_ACCUM) && (smp_cnt == SMP_MAX);

  // Dropping enable abandons any partial block; the FIFO keeps what it already holds.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= ST_IDLE;
      fill_cnt <= '0;
      smp_cnt  <= '0;
      acc      <= '0;
    end else if (!enable_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= (FILL_CYCLES == 0) ? ST_ACCUM : ST_FILL;
          fill_cnt <= '0;
          smp_cnt  <= '0;
          acc      <= '0;
        end
        ST_FILL: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == FILL_LAST) state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (smp_cnt == SMP_MAX) begin
            smp_cnt <= '0;
            acc     <= '0;
          end else begin
            smp_cnt <= smp_cnt + 1'b1;
            acc     <= acc_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LEVEL);
  assign pop     = !empty && bus_if.ready_i;
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  // A pop on the same edge frees the slot, so a push into a full FIFO can still land.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= acc_next;
        wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni)      overflow_o <= 1'b0;
    else if (drop)      overflow_o <= 1'b1;
    else if (clr_ovf_i) overflow_o <= 1'b0;
  end

  assign level_o        = level_q;
  assign bus_if.valid_o = !empty;
  assign bus_if.data_o  = empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_adc_pipe_decimator_fifo.sv
// Directed plus randomized bench for adc_pipe_decimator_fifo against a queue-based model
// that tracks the sample index since enable.
module tb_adc_pipe_decimator_fifo;
  localparam int NUM_BITS = 3;
  localparam int AVG_LOG2 = 2;
  localparam int FDL2     = 2;
  localparam int FILL     = 3;
  localparam int NSMP     = 1 << AVG_LOG2;
  localparam int DEPTH    = 1 << FDL2;
  localparam int OUT_BITS = NUM_BITS + AVG_LOG2;

  logic                clock_i = 1'b0;
  logic                reset_n;
  logic                enable;
  logic [NUM_BITS-1:0] d;
  logic                ready;
  logic                clr;
  logic [FDL2:0]       level;
  logic                overflow;

  int checks = 0;
  int errors = 0;

  adc_pipe_decimator_fifo_if #(.DATA_BITS(OUT_BITS)) bus ();
  assign bus.ready_i = ready;

  adc_pipe_decimator_fifo #(
    .NUM_BITS(NUM_BITS), .AVG_LOG2(AVG_LOG2), .FIFO_DEPTH_LOG2(FDL2), .FILL_CYCLES(FILL)
  ) dut (
    .clock_i(clock_i), .reset_ni(reset_n), .enable_i(enable), .d_i(d),
    .clr_ovf_i(clr), .level_o(level), .overflow_o(overflow), .bus_if(bus)
  );

  always #5 clock_i = ~clock_i;

  // Model: k counts edges since enable was first seen high; sample s = k-FILL-1 closes a block when s%NSMP==NSMP-1.
  int  m_q[$];
  bit  m_ovf;
  bit  m_run;
  int  m_k;
  int  m_sum;
  bit  m_push;
  bit  m_pop;
  int  m_word;
  int  m_s;

  always @(posedge clock_i or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_ovf = 0; m_run = 0; m_k = 0; m_sum = 0;
    end else begin
      m_push = 0;
      m_pop  = (m_q.size() > 0) && ready;
      if (!enable) begin
        m_run = 0;
      end else if (!m_run) begin
        m_run = 1; m_k = 0; m_sum = 0;
      end else begin
        m_k++;
        if (m_k > FILL) begin
          m_s   = m_k - FILL - 1;
          m_sum = m_sum + int'(d);
          if (m_s % NSMP == NSMP - 1) begin
            m_push = 1; m_word = m_sum; m_sum = 0;
          end
        end
      end
      if (m_pop) void'(m_q.pop_front());
      if (clr) m_ovf = 0;
      if (m_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_word);
        else m_ovf = 1;
      end
    end
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".valid"}, 32'(bus.valid_o), 32'(m_q.size() > 0));
    checkValue({tag, ".data"}, 32'(bus.data_o), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    checkValue({tag, ".level"}, 32'(level), 32'(m_q.size()));
    checkValue({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic applyStimulus(input logic en, input int dv, input logic rdy, input logic cl);
    enable = en;
    d      = NUM_BITS'(dv);
    ready  = rdy;
    clr    = cl;
  endtask

  task automatic cycle(input string tag);
    @(posedge clock_i);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b1, 7, 1'b1, 1'b0);
    #3;
    checkValue("rst.valid", 32'(bus.valid_o), 0);
    checkValue("rst.data", 32'(bus.data_o), 0);
    checkValue("rst.level", 32'(level), 0);
    checkValue("rst.ovf", 32'(overflow), 0);
    cycle("rst_clk");
    reset_n = 1'b1;

    $display("[TB] constant 5 stream");
    applyStimulus(1'b1, 5, 1'b1, 1'b0);
    for (int e = 0; e < 16; e++) begin
      cycle("const5");
      if (e == 6) checkValue("const5.not_yet", 32'(bus.valid_o), 0);
      if (e == 7) begin
        checkValue("const5.first_valid", 32'(bus.valid_o), 1);
        checkValue("const5.first_data", 32'(bus.data_o), 20);
      end
      if (e == 11) checkValue("const5.second_data", 32'(bus.data_o), 20);
    end

    $display("[TB] ramp stream");
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    cycle("ramp_idle");
    for (int e = 0; e < 32; e++) begin
      applyStimulus(1'b1, (e + 4) % 8, 1'b1, 1'b0);
      cycle("ramp");
      if (e == 7)  checkValue("ramp.word0", 32'(bus.data_o), 6);
      if (e == 11) checkValue("ramp.word1", 32'(bus.data_o), 22);
      if (e == 15) checkValue("ramp.word2", 32'(bus.data_o), 6);
    end

    $display("[TB] fill to overflow");
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    cycle("ovf_idle");
    applyStimulus(1'b1, 7, 1'b0, 1'b0);
    for (int e = 0; e < 24; e++) begin
      cycle("ovf");
      if (e == 7)  checkValue("ovf.level1", 32'(level), 1);
      if (e == 11) checkValue("ovf.level2", 32'(level), 2);
      if (e == 19) checkValue("ovf.level4", 32'(level), 4);
      if (e == 22) checkValue("ovf.not_set", 32'(overflow), 0);
    end
    checkValue("ovf.level_held", 32'(level), 4);
    checkValue("ovf.sticky", 32'(overflow), 1);
    checkValue("ovf.data28", 32'(bus.data_o), 28);
    applyStimulus(1'b1, 7, 1'b0, 1'b1);
    cycle("ovf_clr");
    checkValue("ovf.cleared", 32'(overflow), 0);

    $display("[TB] push and pop while full");
    applyStimulus(1'b1, 7, 1'b0, 1'b0);
    cycle("full_wait");
    cycle("full_wait");
    applyStimulus(1'b1, 7, 1'b1, 1'b0);
    cycle("full_pushpop");
    checkValue("full.level_kept", 32'(level), 4);
    checkValue("full.no_ovf", 32'(overflow), 0);

    $display("[TB] enable drop and re-enable");
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    for (int e = 0; e < 6; e++) cycle("drain");
    checkValue("drain.empty", 32'(level), 0);
    for (int e = 0; e < 6; e++) begin
      applyStimulus(1'b1, $urandom_range(0, 7), 1'b1, 1'b0);
      cycle("partial");
    end
    applyStimulus(1'b0, 7, 1'b1, 1'b0);
    for (int e = 0; e < 6; e++) cycle("partial_drop");
    checkValue("partial.no_push", 32'(level), 0);
    applyStimulus(1'b1, 3, 1'b1, 1'b0);
    for (int e = 0; e < 10; e++) begin
      cycle("reenable");
      if (e == 6) checkValue("reenable.not_yet", 32'(bus.valid_o), 0);
      if (e == 7) checkValue("reenable.sum", 32'(bus.data_o), 12);
    end
    applyStimulus(1'b1, 7, 1'b0, 1'b0);
    for (int e = 0; e < 20; e++) cycle("prefill");
    #2;
    reset_n = 1'b0;
    #1;
    checkValue("async.valid", 32'(bus.valid_o), 0);
    checkValue("async.data", 32'(bus.data_o), 0);
    checkValue("async.level", 32'(level), 0);
    checkValue("async.ovf", 32'(overflow), 0);
    @(posedge clock_i);
    #1;
    reset_n = 1'b1;

    $display("[TB] randomized stream");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom % 24) != 0, $urandom_range(0, 7),
                    (i < 300) ? (($urandom % 3) != 0) : (($urandom % 6) == 0),
                    ($urandom % 25) == 0);
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
